// File: rtl/ir_pkg.sv
// Shared NEC receiver definitions: decoder FSM states and pulse-width windows
// (all bounds in microseconds, i.e. in timing ticks).
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } ir_state_e;

  localparam int unsigned LEAD_MARK_MIN  = 8500;
  localparam int unsigned LEAD_MARK_MAX  = 9500;
  localparam int unsigned LEAD_SPACE_MIN = 4000;
  localparam int unsigned LEAD_SPACE_MAX = 5000;
  localparam int unsigned REP_SPACE_MIN  = 2000;
  localparam int unsigned REP_SPACE_MAX  = 2500;
  localparam int unsigned BIT_MARK_MIN   = 400;
  localparam int unsigned BIT_MARK_MAX   = 700;
  localparam int unsigned ZERO_SPACE_MIN = 400;
  localparam int unsigned ZERO_SPACE_MAX = 700;
  localparam int unsigned ONE_SPACE_MIN  = 1500;
  localparam int unsigned ONE_SPACE_MAX  = 1900;
  localparam int unsigned STOP_MARK_MIN  = 400;
  localparam int unsigned STOP_MARK_MAX  = 700;

  function automatic logic in_win(input logic [15:0] width,
                                  input int unsigned lo,
                                  input int unsigned hi);
    return ({16'd0, width} >= lo) && ({16'd0, width} <= hi);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Produces a single-clk enable every CLK_DIV clk cycles; the 1 us timebase
// for the NEC width counter.
module ir_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_div;
  logic          r_tick;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == CW'(CLK_DIV - 1)) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder. Define IR_NEC_CHECK_EN to reject 32-bit frames
// whose top byte is not the inverse of the command byte.
module ir_nec_rx
  import ir_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int DATA_BITS  = 32,
  parameter int TIMEOUT_US = 12000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ir_rxb,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_repeat,
  output logic                 o_err,
  output logic                 o_busy
);

  logic [1:0]           r_sync;
  logic                 r_mark_d;
  logic [15:0]          r_cnt;
  ir_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [5:0]           r_bits, w_bits_nxt;
  logic                 r_rep, w_rep_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_repeat, r_err, r_seen_valid;
  logic                 w_valid_nxt, w_repeat_nxt, w_err_nxt;
  logic                 w_tick, w_mark, w_edge, w_rise, w_fall, w_timeout;
  logic                 w_zero, w_one, w_chk_ok;

  ir_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_mark    = ~r_sync[1];
  assign w_edge    = w_mark ^ r_mark_d;
  assign w_rise    = w_edge & w_mark;
  assign w_fall    = w_edge & ~w_mark;
  assign w_timeout = (r_state != IDLE) && ({16'd0, r_cnt} > 32'(TIMEOUT_US));
  assign w_zero    = in_win(r_cnt, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
  assign w_one     = in_win(r_cnt, ONE_SPACE_MIN, ONE_SPACE_MAX);

`ifdef IR_NEC_CHECK_EN
  logic [31:0] w_chk_word;
  assign w_chk_word = 32'(r_shift);
  assign w_chk_ok   = (DATA_BITS != 32) || (w_chk_word[31:24] == ~w_chk_word[23:16]);
`else
  assign w_chk_ok   = 1'b1;
`endif

  // Synchroniser idles high (no carrier); the width counter restarts on
  // every level change, so at an edge it holds the width of the level that just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_mark_d <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync   <= {r_sync[0], i_ir_rxb};
      r_mark_d <= w_mark;
      if (w_edge)
        r_cnt <= '0;
      else if (w_tick && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bits_nxt   = r_bits;
    w_rep_nxt    = r_rep;
    w_valid_nxt  = 1'b0;
    w_repeat_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_err_nxt   = 1'b1;
    end else if (w_edge) begin
      case (r_state)
        IDLE:       if (w_rise) w_state_nxt = LEAD_MARK;
        LEAD_MARK:  if (in_win(r_cnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) w_state_nxt = LEAD_SPACE;
                    else begin w_state_nxt = IDLE; w_err_nxt = 1'b1; end
        LEAD_SPACE: if (in_win(r_cnt, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                      w_state_nxt = BIT_MARK;
                      w_bits_nxt  = '0;
                      w_rep_nxt   = 1'b0;
                    end else if (in_win(r_cnt, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                      w_state_nxt = STOP_MARK;
                      w_rep_nxt   = 1'b1;
                    end else begin
                      w_state_nxt = IDLE;
                      w_err_nxt   = 1'b1;
                    end
        BIT_MARK:   if (in_win(r_cnt, BIT_MARK_MIN, BIT_MARK_MAX)) w_state_nxt = BIT_SPACE;
                    else begin w_state_nxt = IDLE; w_err_nxt = 1'b1; end
        BIT_SPACE:  if (w_zero || w_one) begin
                      w_shift_nxt = {w_one, r_shift[DATA_BITS-1:1]};
                      w_bits_nxt  = r_bits + 6'd1;
                      w_state_nxt = (r_bits == 6'(DATA_BITS - 1)) ? STOP_MARK : BIT_MARK;
                    end else begin
                      w_state_nxt = IDLE;
                      w_err_nxt   = 1'b1;
                    end
        STOP_MARK:  begin
                      w_state_nxt = IDLE;
                      if (!in_win(r_cnt, STOP_MARK_MIN, STOP_MARK_MAX)) w_err_nxt = 1'b1;
                      else if (r_rep) begin
                        w_repeat_nxt = r_seen_valid;
                        w_err_nxt    = ~r_seen_valid;
                      end else begin
                        w_valid_nxt = w_chk_ok;
                        w_err_nxt   = ~w_chk_ok;
                      end
                    end
        default:    w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bits       <= '0;
      r_rep        <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_repeat     <= 1'b0;
      r_err        <= 1'b0;
      r_seen_valid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bits   <= w_bits_nxt;
      r_rep    <= w_rep_nxt;
      r_valid  <= w_valid_nxt;
      r_repeat <= w_repeat_nxt;
      r_err    <= w_err_nxt;
      if (w_valid_nxt) begin
        r_data       <= r_shift;
        r_seen_valid <= 1'b1;
      end
    end
  end

  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_repeat = r_repeat;
  assign o_err    = r_err;
  assign o_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_ir_nec_rx.sv
// Self-checking bench for ir_nec_rx: table of frame/repeat vectors plus
// hand-written error, timeout and reset sequences, checked via a scoreboard.
module tb_ir_nec_rx;

  localparam int CLK_DIV   = 2;
  localparam int DATA_BITS = 32;
  localparam int TIMEOUT   = 12000;

  typedef enum logic [1:0] {EV_NONE, EV_VALID, EV_REPEAT, EV_ERR} ev_e;
  typedef enum logic [1:0] {SEQ_FRAME, SEQ_REPEAT, SEQ_BADLEAD} seq_e;

  typedef struct {
    ev_e         kind;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    seq_e        seq;
    logic [31:0] payload;
    ev_e         exp_kind;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_ir_rxb = 1'b1;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid, o_repeat, o_err, o_busy;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  time         t_evt = 0;
  logic [31:0] model_data = '0;

  ir_nec_rx #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .TIMEOUT_US(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ir_rxb (i_ir_rxb),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_repeat (o_repeat),
    .o_err    (o_err),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input level changes happen 1 ns after a rising edge.
  task automatic hold(input logic mark, input int us);
    i_ir_rxb = ~mark;
    repeat (us * CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, 560);
    hold(1'b0, b ? 1690 : 560);
  endtask

  task automatic send_frame(input logic [31:0] d);
    hold(1'b1, 9000);
    hold(1'b0, 4500);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
    hold(1'b1, 560);
    hold(1'b0, 1000);
  endtask

  task automatic send_repeat();
    hold(1'b1, 9000);
    hold(1'b0, 2250);
    hold(1'b1, 560);
    hold(1'b0, 1000);
  endtask

  task automatic expect_ev(input ev_e kind);
    exp_t e;
    if (kind == EV_VALID) model_data = model_data;
    e.kind = kind;
    e.data = model_data;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  initial begin
    ev_e  kind;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (o_valid || o_repeat || o_err)) begin
        t_evt = $time;
        check("single pulse flag", 64'(o_valid) + 64'(o_repeat) + 64'(o_err), 64'd1);
        kind = o_valid ? EV_VALID : (o_repeat ? EV_REPEAT : EV_ERR);
        if (sb_q.size() == 0) begin
          check("unexpected pulse", 64'(kind), 64'(EV_NONE));
        end else begin
          e = sb_q.pop_front();
          check("event kind", 64'(kind), 64'(e.kind));
          check("o_data at event", 64'(o_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   lat;

    vecs[0] = '{SEQ_REPEAT,  32'h0,        EV_ERR};
    vecs[1] = '{SEQ_FRAME,   32'hBA45FF00, EV_VALID};
    vecs[2] = '{SEQ_REPEAT,  32'h0,        EV_REPEAT};
    vecs[3] = '{SEQ_BADLEAD, 32'h0,        EV_ERR};
`ifdef IR_NEC_CHECK_EN
    vecs[4] = '{SEQ_FRAME,   32'hBB45FF00, EV_ERR};
`else
    vecs[4] = '{SEQ_FRAME,   32'hBB45FF00, EV_VALID};
`endif
    vecs[5] = '{SEQ_REPEAT,  32'h0,        EV_REPEAT};

    repeat (5) @(posedge clk);
    #1;
    check("reset o_data",   64'(o_data),   64'd0);
    check("reset o_valid",  64'(o_valid),  64'd0);
    check("reset o_repeat", 64'(o_repeat), 64'd0);
    check("reset o_err",    64'(o_err),    64'd0);
    check("reset o_busy",   64'(o_busy),   64'd0);
    rst_n = 1'b1;
    hold(1'b0, 200);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_kind == EV_VALID) model_data = vecs[v].payload;
      expect_ev(vecs[v].exp_kind);
      case (vecs[v].seq)
        SEQ_FRAME:  send_frame(vecs[v].payload);
        SEQ_REPEAT: send_repeat();
        default: begin
          hold(1'b1, 7000);
          hold(1'b0, 4500);
        end
      endcase
      wait_drain("vector completion");
      check("o_data after vector", 64'(o_data), 64'(model_data));
      check("o_busy after vector", 64'(o_busy), 64'd0);
    end

    // Bit 10 space of 1100 us falls in neither bit window.
    expect_ev(EV_ERR);
    hold(1'b1, 9000);
    hold(1'b0, 4500);
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    hold(1'b1, 560);
    hold(1'b0, 1100);
    hold(1'b1, 560);
    hold(1'b0, 1000);
    wait_drain("bit10 error");
    check("bit10 o_data kept", 64'(o_data), 64'(model_data));
    check("bit10 o_busy", 64'(o_busy), 64'd0);

    // Mark stuck for 13 ms after the lead space: error 12001 ticks in.
    expect_ev(EV_ERR);
    hold(1'b1, 9000);
    hold(1'b0, 4500);
    t_evt = 0;
    begin
      time t0;
      t0 = $time;
      hold(1'b1, 13000);
      hold(1'b0, 1000);
      wait_drain("timeout error");
      lat = int'((t_evt - t0) / 10);
    end
    check("timeout latency in window",
          64'((lat >= TIMEOUT * CLK_DIV + 5) && (lat <= (TIMEOUT + 1) * CLK_DIV + 5)), 64'd1);
    check("timeout o_data kept", 64'(o_data), 64'(model_data));
    check("timeout o_busy", 64'(o_busy), 64'd0);

    // Reset mid-frame: no pulse, state cleared, history of o_valid forgotten.
    hold(1'b1, 9000);
    hold(1'b0, 4500);
    send_bit(1'b1);
    send_bit(1'b0);
    hold(1'b1, 300);
    check("busy mid-frame", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    i_ir_rxb = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid-frame reset o_data", 64'(o_data), 64'd0);
    check("mid-frame reset o_busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;
    model_data = '0;
    hold(1'b0, 1000);
    check("no pulse after reset", 64'(sb_q.size()), 64'd0);

    expect_ev(EV_ERR);
    send_repeat();
    wait_drain("repeat after reset");

    model_data = 32'hFF000001;
    expect_ev(EV_VALID);
    send_frame(32'hFF000001);
    wait_drain("frame after reset");
    check("frame after reset o_data", 64'(o_data), 64'(model_data));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_nec_rx.md
IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning clk cycles per 1 us timing tick (legal range 2..1023).
REQ-002 SHALL have parameter DATA_BITS, default 32, meaning payload bits per frame (legal range 8..32).
REQ-003 SHALL have parameter TIMEOUT_US, default 12000, meaning the maximum legal single-level duration inside a frame.
REQ-004 SHALL use clk  input  1  system clock; all logic runs in this single clock domain.
REQ-005 SHALL use rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have i_ir_rxb  input  1  raw, inverted IR receiver output (low = carrier present = mark).
REQ-007 SHALL have o_data  output  DATA_BITS  last accepted payload, LSB = first received bit.
REQ-008 SHALL have o_valid  output  1  one-clk pulse when o_data is updated.
REQ-009 SHALL have o_repeat  output  1  one-clk pulse on an accepted repeat code.
REQ-010 SHALL have o_err  output  1  one-clk pulse on a rejected frame.
REQ-011 SHALL have o_busy  output  1  high while the FSM is outside IDLE.

Function
REQ-012 SHALL pass i_ir_rxb through a two-flop synchroniser, then invert it to form mark.
REQ-013 SHALL derive a one-clk tick enable every CLK_DIV clk cycles, with no generated or derived clocks.
REQ-014 SHALL measure each mark and space in ticks with a 16-bit counter that saturates at 0xFFFF, cleared on each level change.
REQ-015 SHALL use FSM states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
REQ-016 SHALL make the IDLE->LEAD_MARK transition on a mark rising edge.
REQ-017 SHALL, on a lead mark of 8500..9500 us, go to LEAD_SPACE; on any other lead-mark length, flag an error.
REQ-018 SHALL, on a lead space of 4000..5000 us, go to BIT_MARK with the bit count cleared.
REQ-019 SHALL, on a lead space of 2000..2500 us, go to STOP_MARK with a repeat flag set.
REQ-020 SHALL require each bit mark to be 400..700 us.
REQ-021 SHALL decode a bit space of 400..700 us as 0 and 1500..1900 us as 1, shifting bits in LSB-first.
REQ-022 SHALL, after DATA_BITS bits, go to STOP_MARK; a stop mark of 400..700 us completes the frame.
REQ-023 SHALL, on frame completion, load o_data and pulse o_valid on the same clk edge as the STOP_MARK->IDLE transition.
REQ-024 SHALL, on repeat completion, pulse o_repeat only if at least one o_valid has occurred since reset; otherwise o_err SHALL pulse.
REQ-025 SHALL treat any out-of-window width as an error: pulse o_err, return to IDLE, leave o_data unchanged.
REQ-026 SHALL treat a level held for more than TIMEOUT_US in any non-IDLE state as an error with the same behaviour as REQ-025.
REQ-027 SHALL NOT allow o_valid, o_repeat and o_err to be high in the same cycle.
REQ-028 SHALL ignore a new lead mark that arrives mid-frame; the frame fails on width check instead.

Reset
REQ-029 SHALL, on asynchronous rst_n assertion, set o_data=0, o_valid=0, o_repeat=0, o_err=0, o_busy=0, FSM=IDLE, counters=0, synchroniser=idle (no mark).
REQ-030 SHALL abort a reset asserted mid-frame with no pulse; the first frame after release is decoded normally.

Configuration
REQ-031 SHALL support macro IR_NEC_CHECK_EN; when it is defined and DATA_BITS==32, a frame SHALL be accepted only if data[31:24]==~data[23:16]; a failure pulses o_err instead of o_valid.
REQ-032 SHALL, when IR_NEC_CHECK_EN is undefined, perform no payload integrity check.

Structure
REQ-033 SHALL place the FSM state enum and all timing window constants (lead, repeat, bit, stop bounds in us) in shared package ir_pkg.
REQ-034 SHALL implement the tick enable in sub-module ir_tick_gen (parameter CLK_DIV; ports clk, rst_n, o_tick).

Verification
REQ-035 SHALL verify: NEC frame bytes 0x00,0xFF,0x45,0xBA -> single o_valid pulse, o_data=0xBA45FF00.
REQ-036 SHALL verify: valid frame then a 9 ms mark + 2.25 ms space + 560 us stop -> o_repeat pulse, o_data unchanged.
REQ-037 SHALL verify: a repeat code immediately after reset -> o_err pulse, no o_repeat.
REQ-038 SHALL verify: bit 10 space of 1100 us -> o_err pulse, FSM IDLE, o_data keeps its previous value.
REQ-039 SHALL verify: line held marked for 13 ms after the lead space -> o_err pulse at 12000 us + 1 tick.
REQ-040 SHALL verify: with IR_NEC_CHECK_EN, cmd 0x45 with inverse byte 0xBB -> o_err pulse and no o_valid; without the macro, o_valid pulses with o_data=0xBB45FF00.
